// File: rtl/vslc_timer_bank.sv
// Bank of independent two-phase timer channels driven by one shared prescaler tick.
// Each channel runs PHASE_A then PHASE_B, in periodic, one-shot or toggle mode.
module vslc_timer_bank #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                prescale,
    input  logic [CHANNELS-1:0]       enable,
    input  logic [2*CHANNELS-1:0]     mode,
    input  logic [WIDTH*CHANNELS-1:0] period_a,
    input  logic [WIDTH*CHANNELS-1:0] period_b,
    output logic [CHANNELS-1:0]       timer_out,
    output logic [CHANNELS-1:0]       done,
    output logic [WIDTH*CHANNELS-1:0] counter_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PHASE_A = 2'd1,
        PHASE_B = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_TOGGLE  = 2'b10;

    logic [7:0] presc_reg;
    logic       tick;

    // ">=" rather than "==" so lowering prescale mid-count never stalls the tick.
    assign tick = (presc_reg >= prescale);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_reg <= 8'd0;
        end else if (tick) begin
            presc_reg <= 8'd0;
        end else begin
            presc_reg <= presc_reg + 8'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
            state_t           state_reg, state_next;
            logic [WIDTH-1:0] count_reg, count_next;
            logic             out_reg, out_next;
            logic             done_reg, done_next;
            logic [1:0]       mode_reg, mode_next;
            logic [WIDTH-1:0] active_period;
            logic             phase_end;

            // Period is compared live, so a lowered period ends the phase on the next tick.
            assign active_period = (state_reg == PHASE_B) ? period_b[gi*WIDTH +: WIDTH]
                                                          : period_a[gi*WIDTH +: WIDTH];
            assign phase_end     = tick && (count_reg >= active_period);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= IDLE;
                    count_reg <= '0;
                    out_reg   <= 1'b0;
                    done_reg  <= 1'b0;
                    mode_reg  <= 2'b00;
                end else begin
                    state_reg <= state_next;
                    count_reg <= count_next;
                    out_reg   <= out_next;
                    done_reg  <= done_next;
                    mode_reg  <= mode_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                count_next = count_reg;
                out_next   = out_reg;
                done_next  = 1'b0;
                mode_next  = mode_reg;
                if (!enable[gi]) begin
                    state_next = IDLE;
                    count_next = '0;
                    out_next   = 1'b0;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            state_next = PHASE_A;
                            count_next = '0;
                            out_next   = 1'b0;
                            mode_next  = mode[gi*2 +: 2];
                        end
                        PHASE_A: begin
                            if (phase_end) begin
                                state_next = PHASE_B;
                                count_next = '0;
                                if (mode_reg != MODE_TOGGLE) begin
                                    out_next = 1'b1;
                                end
                            end else if (tick) begin
                                count_next = count_reg + WIDTH'(1);
                            end
                        end
                        PHASE_B: begin
                            if (phase_end) begin
                                count_next = '0;
                                done_next  = 1'b1;
                                if (mode_reg == MODE_ONESHOT) begin
                                    state_next = HALT;
                                    out_next   = 1'b0;
                                end else begin
                                    state_next = PHASE_A;
                                    out_next   = (mode_reg == MODE_TOGGLE) ? ~out_reg : 1'b0;
                                end
                            end else if (tick) begin
                                count_next = count_reg + WIDTH'(1);
                            end
                        end
                        HALT: begin
                            count_next = '0;
                            out_next   = 1'b0;
                        end
                        default: begin
                            state_next = IDLE;
                            count_next = '0;
                            out_next   = 1'b0;
                        end
                    endcase
                end
            end

            assign timer_out[gi]                 = out_reg;
            assign done[gi]                      = done_reg;
            assign counter_o[gi*WIDTH +: WIDTH]  = count_reg;
        end
    endgenerate

endmodule
